io_timer_counter: RTL
=====================

Name: io_timer_counter

Overview:
Memory-mapped dual 16-bit timer/counter peripheral sitting directly downstream of the CPU's MEM stage on the I/O bus.
- Consumes the MEM-stage bus: address from alu_outM, write data from write_dataM[15:0], write strobe from memwriteM, read strobe from mem2regM.
- Returns read data onto the CPU's io_data input.
- Each channel either counts down on every clock (timer mode) or counts external pulse rising edges (counter mode), and raises a one-cycle cout pulse on expiry.

Parameters:
BASE_ADDR, 32'hFFFFFC20, base of the 16-byte register window; bits [3:0] must be 0.
CNT_W, 16, counter/register width.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
isR  in  1  bus read strobe (mem2regM)
isW  in  4  bus byte write enables (memwriteM); any nonzero bit means a write
addr  in  32  bus address (alu_outM)
dW  in  16  write data (write_dataM[15:0])
dR  out  16  read data, registered, zero-extended by top level onto io_data
pulse1  in  1  channel 0 external count input, asynchronous
pulse2  in  1  channel 1 external count input, asynchronous
cout1  out  1  channel 0 expiry pulse
cout2  out  1  channel 1 expiry pulse

Behaviour:
- Address decode:
  - sel = (addr[31:4] == BASE_ADDR[31:4]).
  - Register index = addr[3:1]; addr[0] is ignored.
- Register map (offsets from BASE_ADDR):
  - 0x0: CTRL0 on write, STAT0 on read.
  - 0x2: CTRL1 on write, STAT1 on read.
  - 0x4: INIT0 on write, CNT0 on read.
  - 0x6: INIT1 on write, CNT1 on read.
  - 0x8–0xE: reads return 0; writes are ignored.
- CTRL bits:
  - [0] mode: 0 = timer (tick every clk), 1 = counter (tick on synchronized pulse rising edge).
  - [1] repeat: auto-reload on expiry.
  - [2] enable.
  - Other bits are ignored.
- STAT bits:
  - [15] running.
  - [1] overflow: expiry while done was still set.
  - [0] done.
  - Other bits read 0.
- Reset:
  - All CTRL, INIT and CNT registers = 0.
  - running, done and overflow = 0.
  - dR = 0; cout1 = cout2 = 0.
  - Pulse synchronizer flops = 0.
- Read:
  - A read is the cycle where isR && sel.
  - dR is updated on the next clock edge with the register value from before that edge.
  - dR holds its value when no read is in progress.
  - Reading STATn clears donen and overflown at the same edge.
- Write:
  - A write is the cycle where isW != 0 && sel.
  - Registers are updated at the clock edge.
  - Simultaneous isR and isW: the write takes effect and the read returns the old value.
- Per-channel state machine, with states IDLE and RUN:
  - IDLE -> RUN when enable = 1 and INIT != 0. This is checked every cycle. On entry, CNT is loaded with INIT.
  - Writing INIT (in any state) loads both INIT and CNT with dW. After that write, the channel is in RUN iff enable = 1 and dW != 0.
  - Writing CTRL with enable = 0 -> IDLE. CNT freezes.
  - In RUN, on each tick:
    - If CNT > 1: CNT decrements by 1.
    - If CNT == 1 (expiry): coutn is 1 for exactly one cycle after the edge, done is set, and overflow is set if done was already 1.
    - On expiry with repeat = 1: CNT reloads INIT and the channel stays in RUN.
    - On expiry with repeat = 0: CNT becomes 0 and the channel goes to IDLE. It does not restart until INIT or CTRL is written again.
  - The running bit = (state == RUN).
- Counter mode:
  - pulse passes through a 2-flop synchronizer, then a rising-edge detector.
  - A tick occurs 3 clk edges after the pulse rises.
  - Pulses narrower than 1 clk period are not guaranteed to count.
- Timer-mode latency: after INIT = N is written with enable = 1, cout fires N cycles after the write edge.
- Priority within one edge, for the same channel:
  - Write INIT/CTRL beats a tick; the tick is lost.
  - Set done beats the clear-on-read; done reads 1 on the next read.
- Reset asserted mid-count: everything returns to reset values on that edge, and any cout in progress is dropped.

Decomposition:
- Package io_timer_pkg holds:
  - Offset constants: OFF_CTRL0, OFF_CTRL1, OFF_INIT0, OFF_INIT1.
  - CTRL bit indices: CTRL_MODE, CTRL_REPEAT, CTRL_EN.
  - STAT bit indices: STAT_RUN, STAT_OVF, STAT_DONE.
  - A state enum: IDLE, RUN.
- One sub-module, timer_channel, instantiated twice. It contains the synchronizer, edge detect, CNT/INIT/CTRL registers, state machine and cout.
- The top level contains the address decode, per-channel write and read-clear strobes, and the read mux/register.

Test Plan:
- Reset, then read all 4 offsets -> dR = 0x0000 each time; cout1 = cout2 = 0.
- Write CTRL0 = 0x0004, then INIT0 = 5 -> cout1 high exactly on the 5th cycle after the INIT write edge. Then STAT0 = 0x0001; a second STAT0 read returns 0x0000; CNT0 = 0.
- CTRL1 = 0x0007 (counter mode, repeat, enable), INIT1 = 3; drive 7 pulse2 rising edges, each 4 clk high and 4 clk low -> cout2 fires twice, each pulse 1 cycle long, 3 clk after the 3rd and 6th rising edge. Final CNT1 = 2. STAT1 = 0x8003 (running, done, overflow).
- Timer running with CNT0 = 1, and an INIT0 = 10 write lands on the same edge -> no cout1 pulse; CNT0 reads 10.
- Read STAT0 on the same edge channel 0 expires -> dR = 0x8000 or the old value, with done = 0; the next STAT0 read shows done = 1.
- Assert rst while CNT0 = 3 in RUN -> the next read of STAT0 and CNT0 returns 0; cout1 never pulses.

Source files
------------

// File: rtl/io_timer_pkg.sv
// ----------------------------------------------------------------------------
// io_timer_pkg
//   Shared constants for the dual timer/counter peripheral: register window
//   offsets, CTRL/STAT bit positions and the per-channel state type.
//   No ports (package).
// ----------------------------------------------------------------------------
package io_timer_pkg;

   // Byte offsets inside the 16-byte register window.
   localparam logic [3:0] OFF_CTRL0 = 4'h0;   // CTRL0 write / STAT0 read
   localparam logic [3:0] OFF_CTRL1 = 4'h2;   // CTRL1 write / STAT1 read
   localparam logic [3:0] OFF_INIT0 = 4'h4;   // INIT0 write / CNT0 read
   localparam logic [3:0] OFF_INIT1 = 4'h6;   // INIT1 write / CNT1 read

   // Registers are halfword-addressed, so the decode works on offset[3:1].
   localparam logic [2:0] IDX_CTRL0 = OFF_CTRL0[3:1];
   localparam logic [2:0] IDX_CTRL1 = OFF_CTRL1[3:1];
   localparam logic [2:0] IDX_INIT0 = OFF_INIT0[3:1];
   localparam logic [2:0] IDX_INIT1 = OFF_INIT1[3:1];

   // CTRL register bit positions.
   localparam int CTRL_MODE   = 0;   // 0 = timer, 1 = external pulse counter
   localparam int CTRL_REPEAT = 1;   // auto-reload on expiry
   localparam int CTRL_EN     = 2;   // channel enable

   // STAT register bit positions.
   localparam int STAT_RUN  = 15;
   localparam int STAT_OVF  = 1;
   localparam int STAT_DONE = 0;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } chan_state_e;

endpackage

// File: rtl/timer_channel.sv
// ----------------------------------------------------------------------------
// timer_channel
//   One 16-bit timer/counter channel: pulse synchronizer and rising-edge
//   detector, CTRL/INIT/CNT registers, IDLE/RUN state machine, done/overflow
//   flags and the one-cycle cout expiry pulse.
//
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   pulse      asynchronous external count input
//   ctrl_we    write strobe for CTRL (data on wdata)
//   init_we    write strobe for INIT (data on wdata)
//   rd_clr     STAT is being read: clear done/overflow this edge
//   wdata      write data
//   cnt        current CNT value
//   stat       STAT word (running, overflow, done)
//   cout       expiry pulse, one cycle wide
// ----------------------------------------------------------------------------
module timer_channel
   import io_timer_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pulse,
   input  logic             ctrl_we,
   input  logic             init_we,
   input  logic             rd_clr,
   input  logic [CNT_W-1:0] wdata,
   output logic [CNT_W-1:0] cnt,
   output logic [CNT_W-1:0] stat,
   output logic             cout
);

   chan_state_e      state_q, state_d;
   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             sync3_q, sync3_d;
   logic [2:0]       ctrl_q, ctrl_d;
   logic [CNT_W-1:0] init_q, init_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             armed_q, armed_d;
   logic             done_q, done_d;
   logic             ovf_q, ovf_d;
   logic             cout_q, cout_d;

   logic             tick;
   logic             expiry;

   // sync1/sync2 form the synchronizer; sync3 is the previous synchronized
   // level, so a tick is seen on the third edge after the pulse rises.
   assign tick = ctrl_q[CTRL_MODE] ? (sync2_q & ~sync3_q) : 1'b1;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
         ctrl_q  <= '0;
         init_q  <= '0;
         cnt_q   <= '0;
         armed_q <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         sync3_q <= sync3_d;
         ctrl_q  <= ctrl_d;
         init_q  <= init_d;
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         cout_q  <= cout_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      sync1_d = pulse;
      sync2_d = sync1_q;
      sync3_d = sync2_q;
      state_d = state_q;
      ctrl_d  = ctrl_q;
      init_d  = init_q;
      cnt_d   = cnt_q;
      armed_d = armed_q;
      expiry  = 1'b0;

      // A register write on this edge swallows any tick for the channel.
      if (init_we) begin
         init_d  = wdata;
         cnt_d   = wdata;
         armed_d = 1'b1;
         state_d = (ctrl_q[CTRL_EN] && (wdata != '0)) ? RUN : IDLE;
      end else if (ctrl_we) begin
         ctrl_d  = wdata[2:0];
         armed_d = 1'b1;
         if (!wdata[CTRL_EN]) begin
            state_d = IDLE;
         end
      end else begin
         case (state_q)
            IDLE: begin
               // armed is dropped by a one-shot expiry so the channel does
               // not silently restart until software touches INIT or CTRL.
               if (ctrl_q[CTRL_EN] && (init_q != '0) && armed_q) begin
                  state_d = RUN;
                  cnt_d   = init_q;
               end
            end
            RUN: begin
               if (tick) begin
                  if (cnt_q > CNT_W'(1)) begin
                     cnt_d = cnt_q - CNT_W'(1);
                  end else begin
                     expiry = 1'b1;
                     if (ctrl_q[CTRL_REPEAT]) begin
                        cnt_d = init_q;
                     end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        armed_d = 1'b0;
                     end
                  end
               end
            end
         endcase
      end

      // Setting a flag wins over the clear-on-read of the same edge.
      done_d = (done_q & ~rd_clr) | expiry;
      ovf_d  = (ovf_q & ~rd_clr) | (expiry & done_q);
      cout_d = expiry;
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   always_comb begin
      stat            = '0;
      stat[STAT_RUN]  = (state_q == RUN);
      stat[STAT_OVF]  = ovf_q;
      stat[STAT_DONE] = done_q;
      cnt             = cnt_q;
      cout            = cout_q;
   end

endmodule

// File: rtl/io_timer_counter.sv
// ----------------------------------------------------------------------------
// io_timer_counter
//   Memory-mapped dual 16-bit timer/counter on the CPU I/O bus. Decodes the
//   16-byte window at BASE_ADDR, steers write and clear-on-read strobes to
//   the two channels and registers read data.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   isR             bus read strobe
//   isW[3:0]        bus byte write enables, any set bit = write
//   addr[31:0]      bus address
//   dW[15:0]        write data
//   dR[15:0]        registered read data
//   pulse1, pulse2  asynchronous external count inputs (channel 0 / 1)
//   cout1, cout2    one-cycle expiry pulses (channel 0 / 1)
// ----------------------------------------------------------------------------
module io_timer_counter
   import io_timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'hFFFFFC20,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             isR,
   input  logic [3:0]       isW,
   input  logic [31:0]      addr,
   input  logic [CNT_W-1:0] dW,
   output logic [CNT_W-1:0] dR,
   input  logic             pulse1,
   input  logic             pulse2,
   output logic             cout1,
   output logic             cout2
);

   logic             sel;
   logic             rd;
   logic             wr;
   logic [2:0]       idx;
   logic [1:0]       pulse_vec;
   logic [1:0]       cout_vec;
   logic [1:0]       ctrl_we;
   logic [1:0]       init_we;
   logic [1:0]       rd_clr;
   logic [CNT_W-1:0] stat_w [2];
   logic [CNT_W-1:0] cnt_w  [2];
   logic [CNT_W-1:0] dr_q, dr_d;
   logic             unused_addr_lsb;

   assign sel = (addr[31:4] == BASE_ADDR[31:4]);
   assign idx = addr[3:1];
   assign rd  = isR && sel;
   assign wr  = (isW != 4'b0000) && sel;

   // Byte lane within a halfword does not matter.
   assign unused_addr_lsb = addr[0];

   assign pulse_vec = {pulse2, pulse1};

   for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      localparam logic [2:0] CTRL_IDX = (gi == 0) ? IDX_CTRL0 : IDX_CTRL1;
      localparam logic [2:0] INIT_IDX = (gi == 0) ? IDX_INIT0 : IDX_INIT1;

      assign ctrl_we[gi] = wr && (idx == CTRL_IDX);
      assign init_we[gi] = wr && (idx == INIT_IDX);
      // STAT shares its offset with CTRL.
      assign rd_clr[gi]  = rd && (idx == CTRL_IDX);

      timer_channel #(
         .CNT_W (CNT_W)
      ) u_chan (
         .clk     (clk),
         .rst     (rst),
         .pulse   (pulse_vec[gi]),
         .ctrl_we (ctrl_we[gi]),
         .init_we (init_we[gi]),
         .rd_clr  (rd_clr[gi]),
         .wdata   (dW),
         .cnt     (cnt_w[gi]),
         .stat    (stat_w[gi]),
         .cout    (cout_vec[gi])
      );
   end

   // Read data is captured from the pre-edge register values, so a read
   // that coincides with a write returns the old contents.
   always_comb begin
      dr_d = dr_q;
      if (rd) begin
         case (idx)
            IDX_CTRL0: dr_d = stat_w[0];
            IDX_CTRL1: dr_d = stat_w[1];
            IDX_INIT0: dr_d = cnt_w[0];
            IDX_INIT1: dr_d = cnt_w[1];
            default:   dr_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dr_q <= '0;
      end else begin
         dr_q <= dr_d;
      end
   end

   assign dR    = dr_q;
   assign cout1 = cout_vec[0];
   assign cout2 = cout_vec[1];

endmodule
